// File: rtl/key_conditioner.sv
// key_conditioner: push-button front end for the PLL clock domain.
// Polarity fix, N-flop synchroniser and a four-state debounce FSM producing a clean
// pressed level, one-cycle press/release/long-hold pulses and a press-toggled level.
module key_conditioner #(
    parameter bit          INV_BTN         = 1'b0,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic key_o,
    output logic press_o,
    output logic release_o,
    output logic hold_o,
    output logic toggle_o
);

    localparam int unsigned CntW  = $clog2(DEBOUNCE_CYCLES + 1);
    // Keep hcnt at least one bit wide so HOLD_CYCLES=0 still elaborates.
    localparam int unsigned HcntW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam bit          HoldEn = (HOLD_CYCLES != 0);

    localparam logic [CntW-1:0]  DebLast  = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HcntW-1:0] HoldLast = HcntW'(HOLD_CYCLES - 1);
    localparam logic [HcntW-1:0] HoldMax  = HcntW'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        StReleased,
        StPressWait,
        StPressed,
        StReleaseWait
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state;
    logic [CntW-1:0]        cnt;
    logic [HcntW-1:0]       hcnt;
    logic                   hold_done;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain; polarity is fixed before the first flop so s=1 always means pressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_i ^ INV_BTN};
        end
    end

    // Debounce FSM with all outputs registered; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StReleased;
            cnt       <= '0;
            hcnt      <= '0;
            hold_done <= 1'b0;
            key_o     <= 1'b0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
            hold_o    <= 1'b0;
            toggle_o  <= 1'b0;
        end else begin
            press_o   <= 1'b0;
            release_o <= 1'b0;
            hold_o    <= 1'b0;
            unique case (state)
                StReleased: begin
                    if (s) begin
                        state <= StPressWait;
                        cnt   <= '0;
                    end
                end
                StPressWait: begin
                    if (!s) begin
                        // Bounce: drop back silently.
                        state <= StReleased;
                    end else if (cnt == DebLast) begin
                        state     <= StPressed;
                        key_o     <= 1'b1;
                        press_o   <= 1'b1;
                        toggle_o  <= ~toggle_o;
                        hcnt      <= '0;
                        hold_done <= 1'b0;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                StPressed: begin
                    if (!s) begin
                        state <= StReleaseWait;
                        cnt   <= '0;
                    end else begin
                        if (hcnt != HoldMax) begin
                            hcnt <= hcnt + HcntW'(1);
                        end
                        if (HoldEn && (hcnt == HoldLast) && !hold_done) begin
                            hold_o    <= 1'b1;
                            hold_done <= 1'b1;
                        end
                    end
                end
                StReleaseWait: begin
                    if (s) begin
                        // Release glitch: hcnt/hold_done kept so hold is not re-armed.
                        state <= StPressed;
                    end else if (cnt == DebLast) begin
                        state     <= StReleased;
                        key_o     <= 1'b0;
                        release_o <= 1'b1;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                default: state <= StReleased;
            endcase
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: three instances (default, hold disabled, active-low pin)
// compared every cycle against a run-length reference model, plus directed latency checks.
module tb_key_conditioner;

    localparam int unsigned Sync = 2;
    localparam int unsigned Deb  = 4;
    localparam int unsigned Hold = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key = 1'b0;
    logic key_inv;
    assign key_inv = ~key;

    logic a_key, a_press, a_rel, a_hold, a_tog;
    logic b_key, b_press, b_rel, b_hold, b_tog;
    logic c_key, c_press, c_rel, c_hold, c_tog;

    always #5 clk = ~clk;

    key_conditioner #(
        .INV_BTN(1'b0), .SYNC_STAGES(Sync), .DEBOUNCE_CYCLES(Deb), .HOLD_CYCLES(Hold)
    ) u_dut (
        .clk(clk), .rst(rst), .key_i(key), .key_o(a_key), .press_o(a_press),
        .release_o(a_rel), .hold_o(a_hold), .toggle_o(a_tog)
    );

    key_conditioner #(
        .INV_BTN(1'b0), .SYNC_STAGES(Sync), .DEBOUNCE_CYCLES(Deb), .HOLD_CYCLES(0)
    ) u_dut_nohold (
        .clk(clk), .rst(rst), .key_i(key), .key_o(b_key), .press_o(b_press),
        .release_o(b_rel), .hold_o(b_hold), .toggle_o(b_tog)
    );

    key_conditioner #(
        .INV_BTN(1'b1), .SYNC_STAGES(Sync), .DEBOUNCE_CYCLES(Deb), .HOLD_CYCLES(Hold)
    ) u_dut_inv (
        .clk(clk), .rst(rst), .key_i(key_inv), .key_o(c_key), .press_o(c_press),
        .release_o(c_rel), .hold_o(c_hold), .toggle_o(c_tog)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pin history queue for the synchroniser, a run length of samples
    // disagreeing with the debounced level, and a hold counter for cycles spent settled-pressed.
    bit hist[$];
    bit m_key, m_press, m_rel, m_hold, m_tog;
    int run;
    int hcnt;

    task automatic model_step(input bit r, input bit k);
        bit s;
        bit settled_pressed;
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_hold  = 1'b0;
        if (r) begin
            hist.delete();
            for (int i = 0; i < int'(Sync); i++) hist.push_back(1'b0);
            m_key = 1'b0;
            m_tog = 1'b0;
            run   = 0;
            hcnt  = 0;
        end else begin
            s = hist.pop_front();
            hist.push_back(k);
            settled_pressed = m_key && (run == 0);
            if (s != m_key) run++;
            else run = 0;
            if (run == int'(Deb) + 1) begin
                m_key = s;
                run   = 0;
                if (s) begin
                    m_press = 1'b1;
                    m_tog   = ~m_tog;
                    hcnt    = 0;
                end else begin
                    m_rel = 1'b1;
                end
            end else if (settled_pressed && s && hcnt < int'(Hold)) begin
                hcnt++;
                if (hcnt == int'(Hold)) m_hold = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("key",       int'(a_key),   int'(m_key));
        check_eq("press",     int'(a_press), int'(m_press));
        check_eq("release",   int'(a_rel),   int'(m_rel));
        check_eq("hold",      int'(a_hold),  int'(m_hold));
        check_eq("toggle",    int'(a_tog),   int'(m_tog));
        check_eq("nh_key",    int'(b_key),   int'(m_key));
        check_eq("nh_press",  int'(b_press), int'(m_press));
        check_eq("nh_hold",   int'(b_hold),  0);
        check_eq("nh_toggle", int'(b_tog),   int'(m_tog));
        check_eq("inv_key",   int'(c_key),   int'(m_key));
        check_eq("inv_press", int'(c_press), int'(m_press));
        check_eq("inv_rel",   int'(c_rel),   int'(m_rel));
        check_eq("inv_hold",  int'(c_hold),  int'(m_hold));
        check_eq("inv_tog",   int'(c_tog),   int'(m_tog));
    endtask

    // One clock: drive on negedge, update model at posedge, sample 1 time unit later.
    task automatic tick(input bit r, input bit k);
        @(negedge clk);
        rst = r;
        key = k;
        @(posedge clk);
        model_step(r, k);
        #1;
        compare_all();
    endtask

    // Hold key at k until the selected pulse (0 press, 1 release, 2 hold); n = edges taken, -1 on timeout.
    task automatic wait_pulse(input bit k, input int which, output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            tick(1'b0, k);
            if ((which == 0 && a_press) || (which == 1 && a_rel) || (which == 2 && a_hold)) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int cnt;
        int total;
        bit lvl;
        int len;

        // Reset
        repeat (3) tick(1'b1, 1'b0);
        check_eq("reset_key", int'(a_key), 0);
        repeat (3) tick(1'b0, 1'b0);

        // Clean press
        wait_pulse(1'b1, 0, n);
        check_eq("press_latency", n, 7);
        check_eq("press_toggle", int'(a_tog), 1);

        // Long hold: pulse 16 cycles after key_o rose, then none for the remainder of 40
        wait_pulse(1'b1, 2, n);
        check_eq("hold_latency", n, int'(Hold));
        cnt = 0;
        repeat (24) begin
            tick(1'b0, 1'b1);
            if (a_hold) cnt++;
        end
        check_eq("hold_second", cnt, 0);

        // Release with glitch
        repeat (2) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check_eq("glitch_key", int'(a_key), 1);
        wait_pulse(1'b0, 1, n);
        check_eq("release_latency", n, 7);
        repeat (4) tick(1'b0, 1'b0);

        // Bounce: high3/low1/high2/low1 then steady high
        cnt = 0;
        repeat (3) begin tick(1'b0, 1'b1); if (a_press) cnt++; end
        tick(1'b0, 1'b0); if (a_press) cnt++;
        repeat (2) begin tick(1'b0, 1'b1); if (a_press) cnt++; end
        tick(1'b0, 1'b0); if (a_press) cnt++;
        check_eq("bounce_press", cnt, 0);
        wait_pulse(1'b1, 0, n);
        check_eq("bounce_latency", n, 7);

        // Release and press again so toggle_o=1 before reset
        wait_pulse(1'b0, 1, n);
        check_eq("release2_latency", n, 7);
        wait_pulse(1'b1, 0, n);
        check_eq("press2_latency", n, 7);
        check_eq("pre_reset_toggle", int'(a_tog), 1);

        // Reset while held
        tick(1'b1, 1'b1);
        check_eq("rst_key", int'(a_key), 0);
        check_eq("rst_toggle", int'(a_tog), 0);
        wait_pulse(1'b1, 0, n);
        check_eq("post_rst_latency", n, 7);
        check_eq("post_rst_toggle", int'(a_tog), 1);

        // Random runs of levels, mostly short bounces, some long holds, rare resets
        total = 0;
        while (total < 3000) begin
            lvl = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4))
                                              : int'($urandom_range(5, 30));
            if ($urandom_range(0, 99) == 0) tick(1'b1, lvl);
            repeat (len) tick(1'b0, lvl);
            total += len + 1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
